ins_fetch_queue: RTL and testbench

INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

---
 rtl/ins_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_ins_fetch_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue: streams sequential fetch addresses to a combinational
// code RAM and buffers the returned instructions in a small circular queue.

`ifndef PCWIDTH
`define PCWIDTH 8
`endif
`ifndef INSWIDTH
`define INSWIDTH 32
`endif
`ifndef NOP
`define NOP 14'h3A5C
`endif

module ins_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [`PCWIDTH-1:0]  pcToRam,
  input  logic [`INSWIDTH-1:0] insFromRam,
  output logic [`INSWIDTH-1:0] insOut,
  output logic [`PCWIDTH-1:0]  pcOut,
  output logic                 insValid,
  input  logic                 insTake,
  input  logic                 flush,
  input  logic [`PCWIDTH-1:0]  flushPc,
  output logic [PTRW:0]        count
);

  localparam logic [PTRW:0]        FULL_CNT = (PTRW+1)'(DEPTH);
  localparam logic [PTRW-1:0]      PTR_ONE  = PTRW'(1);
  localparam logic [PTRW:0]        CNT_ONE  = (PTRW+1)'(1);
  localparam logic [`PCWIDTH-1:0]  PC_ONE   = `PCWIDTH'(1);
  localparam logic [`INSWIDTH-1:0] NOP_WORD = {`NOP, 18'd0};

  logic [`INSWIDTH-1:0] ins_mem_q [DEPTH];
  logic [`INSWIDTH-1:0] ins_mem_d [DEPTH];
  logic [`PCWIDTH-1:0]  pc_mem_q  [DEPTH];
  logic [`PCWIDTH-1:0]  pc_mem_d  [DEPTH];

  logic [PTRW-1:0]      head_q, head_d;
  logic [PTRW-1:0]      tail_q, tail_d;
  logic [PTRW:0]        count_q, count_d;
  logic [`PCWIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [`INSWIDTH-1:0] ins_out_q, ins_out_d;
  logic [`PCWIDTH-1:0]  pc_out_q, pc_out_d;
  logic                 valid_q, valid_d;

  logic                 pop_s;
  logic                 push_s;
  logic                 full_s;

  // Next-state logic: queue bookkeeping, fetch address and the registered head view.
  always_comb begin
    full_s = (count_q == FULL_CNT);
    pop_s  = !flush && insTake && valid_q;
    push_s = !flush && (!full_s || pop_s);

    ins_mem_d  = ins_mem_q;
    pc_mem_d   = pc_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;

    if (flush) begin
      head_d     = {PTRW{1'b0}};
      tail_d     = {PTRW{1'b0}};
      count_d    = {(PTRW+1){1'b0}};
      fetch_pc_d = flushPc;
    end else begin
      if (push_s) begin
        ins_mem_d[tail_q] = insFromRam;
        pc_mem_d[tail_q]  = fetch_pc_q;
        tail_d            = tail_q + PTR_ONE;
        fetch_pc_d        = fetch_pc_q + PC_ONE;
      end else begin
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // The head view is computed from next state so the outputs come straight from flops.
    valid_d = (count_d != {(PTRW+1){1'b0}});
    if (valid_d) begin
      ins_out_d = ins_mem_d[head_d];
      pc_out_d  = pc_mem_d[head_d];
    end else begin
      ins_out_d = NOP_WORD;
      pc_out_d  = {`PCWIDTH{1'b0}};
    end
  end

  // State registers with synchronous reset that overrides flush, take and push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= {`INSWIDTH{1'b0}};
        pc_mem_q[i]  <= {`PCWIDTH{1'b0}};
      end
      head_q     <= {PTRW{1'b0}};
      tail_q     <= {PTRW{1'b0}};
      count_q    <= {(PTRW+1){1'b0}};
      fetch_pc_q <= {`PCWIDTH{1'b0}};
      ins_out_q  <= NOP_WORD;
      pc_out_q   <= {`PCWIDTH{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= ins_mem_d[i];
        pc_mem_q[i]  <= pc_mem_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      ins_out_q  <= ins_out_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
    end
  end

  assign pcToRam  = fetch_pc_q;
  assign insOut   = ins_out_q;
  assign pcOut    = pc_out_q;
  assign insValid = valid_q;
  assign count    = count_q;

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Scoreboard bench for ins_fetch_queue: a queue-based reference model predicts the
// visible state after every edge; a monitor pops predictions and compares.

`ifndef PCWIDTH
`define PCWIDTH 8
`endif
`ifndef INSWIDTH
`define INSWIDTH 32
`endif
`ifndef NOP
`define NOP 14'h3A5C
`endif

module tb_ins_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  typedef struct {
    logic [`INSWIDTH-1:0] ins;
    logic [`PCWIDTH-1:0]  pc;
  } entry_t;

  typedef struct {
    int                   cnt;
    logic                 valid;
    logic [`INSWIDTH-1:0] ins;
    logic [`PCWIDTH-1:0]  pc;
    logic [`PCWIDTH-1:0]  fetch;
  } expect_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [`PCWIDTH-1:0]  pc_to_ram;
  logic [`INSWIDTH-1:0] ins_from_ram;
  logic [`INSWIDTH-1:0] ins_out;
  logic [`PCWIDTH-1:0]  pc_out;
  logic                 ins_valid;
  logic                 ins_take = 1'b0;
  logic                 flush = 1'b0;
  logic [`PCWIDTH-1:0]  flush_pc = '0;
  logic [PTRW:0]        count;

  int total = 0;
  int passed = 0;

  entry_t  m_q[$];
  logic [`PCWIDTH-1:0] m_pc = '0;
  expect_t exp_q[$];

  logic [`INSWIDTH-1:0] nop_word;

  // Distinct code per address: the top byte is the address itself.
  function automatic logic [`INSWIDTH-1:0] code_of(input logic [`PCWIDTH-1:0] a);
    return {a, ~a, a ^ 8'h5A, a + 8'd77};
  endfunction

  assign ins_from_ram = code_of(pc_to_ram);

  ins_fetch_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk(clk), .reset(reset), .pcToRam(pc_to_ram), .insFromRam(ins_from_ram),
    .insOut(ins_out), .pcOut(pc_out), .insValid(ins_valid), .insTake(ins_take),
    .flush(flush), .flushPc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one clock edge expressed as queue operations.
  task automatic model_step(input logic r, input logic f, input logic [`PCWIDTH-1:0] fp,
                            input logic t);
    bit do_pop, do_push;
    entry_t e;
    expect_t x;
    if (r) begin
      m_q.delete();
      m_pc = '0;
    end else if (f) begin
      m_q.delete();
      m_pc = fp;
    end else begin
      do_pop  = t && (m_q.size() > 0);
      do_push = (m_q.size() < DEPTH) || do_pop;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.ins = code_of(m_pc);
        e.pc  = m_pc;
        m_q.push_back(e);
        m_pc = m_pc + 8'd1;
      end
    end
    x.cnt   = m_q.size();
    x.valid = (m_q.size() != 0);
    x.ins   = (m_q.size() != 0) ? m_q[0].ins : nop_word;
    x.pc    = (m_q.size() != 0) ? m_q[0].pc : 8'd0;
    x.fetch = m_pc;
    exp_q.push_back(x);
  endtask

  task automatic cycle(input logic r, input logic f, input logic [`PCWIDTH-1:0] fp,
                       input logic t);
    @(negedge clk);
    reset = r; flush = f; flush_pc = fp; ins_take = t;
    model_step(r, f, fp, t);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after each edge, compare the DUT against the oldest prediction.
  initial begin
    expect_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count",    {61'd0, count}, 64'(x.cnt));
        chk("insValid", {63'd0, ins_valid}, {63'd0, x.valid});
        chk("insOut",   {32'd0, ins_out}, {32'd0, x.ins});
        chk("pcOut",    {56'd0, pc_out}, {56'd0, x.pc});
        chk("pcToRam",  {56'd0, pc_to_ram}, {56'd0, x.fetch});
      end
    end
  end

  initial begin
    int flush_left;
    nop_word = {`NOP, 18'd0};

    // Reset state, then fill with no takes.
    cycle(1'b1, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b1, 8'd33, 1'b1);
    settle();
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_insOut", {32'd0, ins_out}, {32'd0, nop_word});
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'd0, 1'b0);
    settle();
    chk("fill_count", {61'd0, count}, 64'd4);
    chk("fill_pcToRam", {56'd0, pc_to_ram}, 64'd4);
    chk("fill_insOut", {32'd0, ins_out}, {32'd0, code_of(8'd0)});
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 8'd0, 1'b0);
    settle();
    chk("hold_pcToRam", {56'd0, pc_to_ram}, 64'd4);

    // Full queue drained and refilled every cycle.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'd0, 1'b1);
    settle();
    chk("stream_insOut", {32'd0, ins_out}, {32'd0, code_of(8'd6)});

    // count=3 then flush with a simultaneous take.
    cycle(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'd0, 1'b0);
    cycle(1'b0, 1'b1, 8'd10, 1'b1);
    settle();
    chk("flush_count", {61'd0, count}, 64'd0);
    chk("flush_pcToRam", {56'd0, pc_to_ram}, 64'd10);
    cycle(1'b0, 1'b0, 8'd0, 1'b0);
    settle();
    chk("after_flush_insOut", {32'd0, ins_out}, {32'd0, code_of(8'd10)});

    // Address wrap from all-ones, then flush held over several cycles.
    cycle(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(40 + i), 1'b1);
    cycle(1'b0, 1'b0, 8'd0, 1'b1);

    // Reset with a full queue.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b1, 8'd99, 1'b1);
    settle();
    chk("rst_full_count", {61'd0, count}, 64'd0);
    chk("rst_full_pcToRam", {56'd0, pc_to_ram}, 64'd0);

    // Randomized traffic with occasional flush bursts and resets.
    flush_left = 0;
    for (int i = 0; i < 500; i++) begin
      if (flush_left == 0 && $urandom_range(0, 15) == 0) flush_left = $urandom_range(1, 3);
      cycle($urandom_range(0, 63) == 0, flush_left > 0, 8'($urandom),
            $urandom_range(0, 2) != 0);
      if (flush_left > 0) flush_left--;
    end

    settle();
    settle();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
